// File: rtl/drift_violation_monitor_pkg.sv
// Shared types for the clock-recovery drift-violation supervisor: clock domain bundle,
// per-channel violation flags, shared leaky-bucket configuration and the channel FSM state.
package common_p;
    typedef struct packed {
        logic clk;
        logic rst;
    } clk_dom_s;
endpackage

package clks_alot_p;
    localparam int VIOLATION_COUNTER_WIDTH = 8;

    typedef struct packed {
        logic hi_pos;
        logic hi_neg;
        logic lo_pos;
        logic lo_neg;
    } drift_violations_s;

    // release_th carries the release threshold; "release" itself is a reserved word.
    typedef struct packed {
        logic [VIOLATION_COUNTER_WIDTH-1:0] hi_growth;
        logic [VIOLATION_COUNTER_WIDTH-1:0] lo_growth;
        logic [VIOLATION_COUNTER_WIDTH-1:0] decay;
        logic [VIOLATION_COUNTER_WIDTH-1:0] sat;
        logic [VIOLATION_COUNTER_WIDTH-1:0] trigger;
        logic [VIOLATION_COUNTER_WIDTH-1:0] release_th;
    } drift_mon_cfg_s;

    typedef enum logic {
        DMON_IDLE    = 1'b0,
        DMON_TRIPPED = 1'b1
    } drift_mon_state_e;
endpackage

// File: rtl/drift_violation_monitor_tracker.sv
// One channel: weighted leaky-bucket counter, IDLE/TRIPPED hysteresis FSM and sticky trip flag.
// trip_next_o is the combinational trip decision so the top can capture first-fault on the same edge.
module drift_channel_tracker
    import clks_alot_p::*;
#(
    parameter int W = VIOLATION_COUNTER_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              clear_i,
    input  logic              event_valid_i,
    input  drift_violations_s viol_i,
    input  drift_mon_cfg_s    cfg_i,
    input  logic              sticky_clear_i,
    output logic [W-1:0]      count_o,
    output drift_mon_state_e  state_o,
    output logic              trip_pulse_o,
    output logic              trip_next_o,
    output logic              sticky_o
);
    logic [W-1:0]     count_q, count_d;
    drift_mon_state_e state_q, state_d;
    logic             trip_pulse_q, trip_pulse_d;
    logic             sticky_q, sticky_d;

    logic             hi_hit, lo_hit;
    logic [W:0]       cnt_x, sum_x, sat_x, decay_x, next_x;

    always_comb begin
        hi_hit       = viol_i.hi_pos | viol_i.hi_neg;
        lo_hit       = viol_i.lo_pos | viol_i.lo_neg;
        cnt_x        = {1'b0, count_q};
        sat_x        = {1'b0, W'(cfg_i.sat)};
        decay_x      = {1'b0, W'(cfg_i.decay)};
        sum_x        = cnt_x + {1'b0, (hi_hit ? W'(cfg_i.hi_growth) : W'(cfg_i.lo_growth))};
        next_x       = cnt_x;
        count_d      = count_q;
        state_d      = state_q;
        trip_pulse_d = 1'b0;

        if (clear_i) begin
            count_d = '0;
            state_d = DMON_IDLE;
        end else if (en_i && event_valid_i) begin
            if (hi_hit || lo_hit) begin
                next_x = (sum_x > sat_x) ? sat_x : sum_x;
            end else begin
                next_x = (cnt_x > decay_x) ? (cnt_x - decay_x) : '0;
            end
            count_d = next_x[W-1:0];
            // Only the check belonging to the current state applies, so a
            // misconfigured release>=trigger still yields one transition per update.
            case (state_q)
                DMON_IDLE: begin
                    if (count_d >= W'(cfg_i.trigger)) begin
                        state_d      = DMON_TRIPPED;
                        trip_pulse_d = 1'b1;
                    end
                end
                DMON_TRIPPED: begin
                    if (count_d <= W'(cfg_i.release_th)) begin
                        state_d = DMON_IDLE;
                    end
                end
                default: state_d = DMON_IDLE;
            endcase
        end

        sticky_d = trip_pulse_d | (sticky_q & ~sticky_clear_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            state_q      <= DMON_IDLE;
            trip_pulse_q <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            count_q      <= count_d;
            state_q      <= state_d;
            trip_pulse_q <= trip_pulse_d;
            sticky_q     <= sticky_d;
        end
    end

    assign count_o      = count_q;
    assign state_o      = state_q;
    assign trip_pulse_o = trip_pulse_q;
    assign trip_next_o  = trip_pulse_d;
    assign sticky_o     = sticky_q;
endmodule

// File: rtl/drift_violation_monitor.sv
// Multi-channel drift-violation supervisor: per-channel trackers, OR-reduced violation
// and a first-fault register recording the lowest-index channel of the first trip.
module drift_violation_monitor
    import clks_alot_p::*;
#(
    parameter int CHANNELS      = 4,
    parameter int COUNTER_WIDTH = clks_alot_p::VIOLATION_COUNTER_WIDTH,
    localparam int ID_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  common_p::clk_dom_s         sys_dom_i,
    input  logic                       recovery_en_i,
    input  logic [CHANNELS-1:0]        clear_state_i,
    input  clks_alot_p::drift_mon_cfg_s cfg_i,
    input  logic [CHANNELS-1:0]        event_valid_i,
    input  drift_violations_s          violations_i [CHANNELS],
    input  logic [CHANNELS-1:0]        sticky_clear_i,
    input  logic                       first_fault_clear_i,
    output logic [CHANNELS-1:0]        violation_o,
    output logic [CHANNELS-1:0]        trip_pulse_o,
    output logic [CHANNELS-1:0]        sticky_o,
    output logic                       any_violation_o,
    output logic                       first_fault_valid_o,
    output logic [ID_W-1:0]            first_fault_ch_o,
    output logic [COUNTER_WIDTH-1:0]   count_o [CHANNELS]
);
    drift_mon_state_e    chan_state [CHANNELS];
    logic [CHANNELS-1:0] trip_next;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        drift_channel_tracker #(.W(COUNTER_WIDTH)) u_trk (
            .clk            (sys_dom_i.clk),
            .rst            (sys_dom_i.rst),
            .en_i           (recovery_en_i),
            .clear_i        (clear_state_i[c]),
            .event_valid_i  (event_valid_i[c]),
            .viol_i         (violations_i[c]),
            .cfg_i          (cfg_i),
            .sticky_clear_i (sticky_clear_i[c]),
            .count_o        (count_o[c]),
            .state_o        (chan_state[c]),
            .trip_pulse_o   (trip_pulse_o[c]),
            .trip_next_o    (trip_next[c]),
            .sticky_o       (sticky_o[c])
        );
        assign violation_o[c] = (chan_state[c] == DMON_TRIPPED);
    end

    assign any_violation_o = |violation_o;

    logic            ff_valid_q, ff_valid_d;
    logic [ID_W-1:0] ff_ch_q, ff_ch_d;
    logic            ff_hit;
    logic [ID_W-1:0] ff_idx;

    always_comb begin
        ff_hit = 1'b0;
        ff_idx = '0;
        // Descending scan so the lowest-index tripping channel is the one left standing.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (trip_next[i]) begin
                ff_hit = 1'b1;
                ff_idx = ID_W'(i);
            end
        end
        ff_valid_d = ff_valid_q;
        ff_ch_d    = ff_ch_q;
        if (first_fault_clear_i) begin
            ff_valid_d = 1'b0;
        end
        if ((!ff_valid_q || first_fault_clear_i) && ff_hit) begin
            ff_valid_d = 1'b1;
            ff_ch_d    = ff_idx;
        end
    end

    always_ff @(posedge sys_dom_i.clk or posedge sys_dom_i.rst) begin
        if (sys_dom_i.rst) begin
            ff_valid_q <= 1'b0;
            ff_ch_q    <= '0;
        end else begin
            ff_valid_q <= ff_valid_d;
            ff_ch_q    <= ff_ch_d;
        end
    end

    assign first_fault_valid_o = ff_valid_q;
    assign first_fault_ch_o    = ff_ch_q;
endmodule
